// File: rtl/mdu_divider.sv
// ============================================================================
// mdu_divider: iterative restoring 32-bit divider for MIPS div/divu (LO/HI)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_divider #(
  parameter int DP_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                is_signed_i,
  input  logic [DP_WIDTH-1:0] dividend_i,
  input  logic [DP_WIDTH-1:0] divisor_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [DP_WIDTH-1:0] quotient_o,
  output logic [DP_WIDTH-1:0] remainder_o,
  output logic                div_by_zero_o
);

  localparam int CW = $clog2(DP_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DP_WIDTH-1:0]   rem_q, rem_d;
  logic [DP_WIDTH-1:0]   quo_q, quo_d;
  logic [DP_WIDTH-1:0]   dvs_q, dvs_d;
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
  logic [DP_WIDTH-1:0]   qres_q, qres_d;
  logic [DP_WIDTH-1:0]   rres_q, rres_d;
  logic                  dbz_q, dbz_d;

  logic                  w_dvd_neg, w_dvs_neg;
  logic [DP_WIDTH-1:0]   w_dvd_mag, w_dvs_mag;
  logic [DP_WIDTH:0]     w_rem_sh;
  logic                  w_ge;
  logic [DP_WIDTH-1:0]   w_diff;

  assign w_dvd_neg = is_signed_i & dividend_i[DP_WIDTH-1];
  assign w_dvs_neg = is_signed_i & divisor_i[DP_WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign w_dvs_mag = w_dvs_neg ? (~divisor_i + 1'b1) : divisor_i;

  // Partial remainder is always below the divisor, so only the shifted value
  // needs the extra bit for an exact compare.
  assign w_rem_sh = {rem_q, quo_q[DP_WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, dvs_q});
  assign w_diff   = w_rem_sh[DP_WIDTH-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    qres_d  = qres_q;
    rres_d  = rres_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            qres_d  = '1;
            rres_d  = dividend_i;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = w_dvd_mag;
            dvs_d   = w_dvs_mag;
            negq_d  = w_dvd_neg ^ w_dvs_neg;
            negr_d  = w_dvd_neg;
            cnt_d   = CW'(DP_WIDTH - 1);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (w_ge) begin
          rem_d = w_diff;
          quo_d = {quo_q[DP_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = w_rem_sh[DP_WIDTH-1:0];
          quo_d = {quo_q[DP_WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        // Truncating division: remainder follows the dividend's sign.
        qres_d  = negq_q ? (~quo_q + 1'b1) : quo_q;
        rres_d  = negr_q ? (~rem_q + 1'b1) : rem_q;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      qres_q  <= '0;
      rres_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      qres_q  <= qres_d;
      rres_q  <= rres_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o        = (state_q == S_DONE);
  assign quotient_o    = qres_q;
  assign remainder_o   = rres_q;
  assign div_by_zero_o = dbz_q;

endmodule

`default_nettype wire
